// File: rtl/alu_execute_stage.sv
// alu_execute_stage: registered ALU execute stage with a 2-entry main/skid output buffer
module alu_execute_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [3:0]       aluControl,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] result,
  output logic             zeroFlag,
  output logic             illegalOp,
  output logic             outValid,
  input  logic             outReady
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
  occ_t state, state_nx;
  logic [WIDTH-1:0] c_res, s_res;
  logic c_ill, c_zero, s_zero, s_ill;
  logic accept, pop;
  assign accept = inValid & inReady;
  assign pop = outValid & outReady;
  assign outValid = state != EMPTY;
  assign c_zero = c_res == '0;
  // Decode the control code; any unknown or x/z code yields an illegal zero result
  always_comb begin
    c_res = '0;
    c_ill = 1'b0;
    case (aluControl)
      4'b0000: c_res = operandA & operandB;
      4'b0001: c_res = operandA | operandB;
      4'b0010: c_res = operandA + operandB;
      4'b0110: c_res = operandA + ~operandB + 1'b1;
      default: c_ill = 1'b1;
    endcase
  end
  // Next occupancy from accept/pop
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = accept ? ONE : EMPTY;
      ONE:     state_nx = (accept && !pop) ? TWO : (pop && !accept) ? EMPTY : ONE;
      TWO:     state_nx = pop ? ONE : TWO;
      default: state_nx = EMPTY;
    endcase
  end
  // Occupancy, registered ready and main/skid entry storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      inReady   <= 1'b1;
      result    <= '0;
      zeroFlag  <= 1'b0;
      illegalOp <= 1'b0;
      s_res     <= '0;
      s_zero    <= 1'b0;
      s_ill     <= 1'b0;
    end else begin
      state   <= state_nx;
      inReady <= state_nx != TWO;
      if (state == TWO && pop) begin
        result    <= s_res;
        zeroFlag  <= s_zero;
        illegalOp <= s_ill;
      end else if (accept && (state == EMPTY || pop)) begin
        result    <= c_res;
        zeroFlag  <= c_zero;
        illegalOp <= c_ill;
      end
      if (state == ONE && accept && !pop) begin
        s_res  <= c_res;
        s_zero <= c_zero;
        s_ill  <= c_ill;
      end
    end
  end
endmodule
